dbg_cmd_frontend: RTL and testbench
===================================

// Module: dbg_cmd_frontend
//
// PURPOSE
//   Host-facing front end of the debug module.
//   - Consumes a byte stream (UART RX side), assembles cmd/addr/data frames and issues them
//     on the debug module's cmd/addr/data/ready interface.
//   - Returns a byte response on an outgoing byte stream (UART TX side).
//   - Sits between the UART byte interfaces and the debug module; owns framing, command
//     sequencing, completion detection and timeouts.
//
// PARAMETERS
//   TIMEOUT_CYCLES  1000000  max cycles between RX bytes within a frame, and max cycles from issue to completion
//   ERR_BYTE        8'hEE    response byte sent when a command times out
//
// PORTS
//   clk          in   1   clock
//   rst_i        in   1   synchronous active-high reset
//   rx_data_i    in   8   incoming host byte
//   rx_valid_i   in   1   rx_data_i valid
//   rx_ready_o   out  1   frontend accepts a byte (transfer = rx_valid_i & rx_ready_o)
//   tx_data_o    out  8   outgoing response byte
//   tx_valid_o   out  1   tx_data_o valid
//   tx_ready_i   in   1   sink accepts a byte (transfer = tx_valid_o & tx_ready_i)
//   dbg_cmd_o    out  8   command to debug module (0x00 = idle)
//   dbg_addr_o   out  32  address to debug module
//   dbg_data_o   out  32  write data to debug module
//   dbg_data_i   in   32  read data from debug module
//   dbg_ready_i  in   1   debug module ready (registered on its side)
//   err_o        out  1   one-cycle pulse on any timeout
//
// BEHAVIOUR
//   Reset (rst_i high at posedge):
//   - State IDLE; counters cleared; partial frame and pending response discarded.
//   - Output values: rx_ready_o=1, tx_valid_o=0, tx_data_o=0, dbg_cmd_o=0x00, dbg_addr_o=0,
//     dbg_data_o=0, err_o=0.
//   - Reset mid-operation: dbg_cmd_o is 0x00 from the first cycle after the reset edge.
//
//   Frame format:
//   - Byte 0 is cmd.
//   - If cmd[7]=1: 4 address bytes follow, LSB first.
//   - Then, if cmd[6]=1: 4 data bytes follow, LSB first.
//   - Frame lengths: 0x00-0x3F = 1 byte; 0x80-0xBF = 5 bytes; 0xC0-0xFF = 9 bytes.
//
//   States IDLE -> RX_ADDR -> RX_DATA -> ISSUE -> WAIT -> TX -> IDLE:
//   - RX_ADDR and RX_DATA are skipped when their cmd bit is 0.
//   - cmd 0x00 skips ISSUE/WAIT and goes straight to TX (ping).
//   - rx_ready_o=1 only in IDLE, RX_ADDR and RX_DATA.
//
//   ISSUE:
//   - dbg_cmd_o=0x00 while dbg_ready_i=0.
//   - On the first cycle with dbg_ready_i=1: dbg_cmd_o=cmd for exactly that cycle, then go to WAIT.
//
//   WAIT:
//   - dbg_cmd_o=cmd while dbg_ready_i=0.
//   - On the first cycle with dbg_ready_i=1: command is complete.
//     - dbg_cmd_o=0x00 in that same cycle (combinational), so the debug module never re-executes.
//     - dbg_data_i is captured in that cycle; go to TX.
//   - A command the debug module completes without ever dropping ready (0x01-0x03) therefore
//     drives cmd for exactly one cycle.
//
//   dbg_addr_o / dbg_data_o:
//   - Registers, written only while RX bytes are assembled.
//   - Stable from ISSUE until the next frame; unused fields read 0 for the new frame.
//
//   TX responses:
//   - Normal: echo of the cmd byte.
//   - If cmd[7:6]=2'b10 (reads 0x80/0x81/0x82): echo is followed by the 4 captured data bytes,
//     LSB first.
//   - tx_data_o is held stable while tx_valid_o=1 and tx_ready_i=0.
//   - After the last byte is accepted: tx_valid_o=0 next cycle, state IDLE.
//
//   Timeout counter:
//   - Cleared on every accepted RX byte and on every state change.
//   - In RX_ADDR/RX_DATA, when the count reaches TIMEOUT_CYCLES:
//     - frame is dropped, err_o pulses, state returns to IDLE; no response is sent.
//   - In ISSUE/WAIT, when the count reaches TIMEOUT_CYCLES:
//     - dbg_cmd_o=0x00, err_o pulses, single-byte response ERR_BYTE.
//   - Counter saturates; its width is $clog2(TIMEOUT_CYCLES+1).
//
//   Simultaneous events:
//   - Timeout and completion in the same WAIT cycle: completion wins.
//   - Timeout and an RX byte in the same cycle: the byte wins.
//
// TESTING (bench uses TIMEOUT_CYCLES=16)
//   1. Memory write
//      - Stimulus: RX C0 00 10 00 00 EF BE AD DE; dbg_ready_i low 3 cycles, then high.
//      - Response: dbg_addr_o=0x00001000, dbg_data_o=0xDEADBEEF, dbg_cmd_o=0xC0 until the
//        ready cycle, 0x00 that same cycle; TX C0.
//   2. Memory read
//      - Stimulus: RX 80 04 00 00 00; completion with dbg_data_i=0x12345678.
//      - Response: TX 80 78 56 34 12.
//   3. Reset everything
//      - Stimulus: RX 03 with dbg_ready_i held 1.
//      - Response: dbg_cmd_o=0x03 for exactly 1 cycle; TX 03; ready to accept the next frame.
//   4. Completion timeout
//      - Stimulus: RX 04 with dbg_ready_i stuck 0 after issue.
//      - Response: after 16 WAIT cycles dbg_cmd_o=0x00, err_o 1-cycle pulse, TX EE.
//   5. Partial frame
//      - Stimulus: RX C0 00, then 16 idle cycles; then RX 82 00 00 00 00.
//      - Response: err_o pulse, no TX, no dbg_cmd_o activity for the partial frame; the 0x82
//        frame then returns 5 bytes.
//   6. Backpressure and reset
//      - Stimulus: tx_ready_i low 5 cycles mid read-response.
//      - Response: tx_data_o stable, all 5 bytes delivered in order.
//      - Stimulus: rst_i in WAIT.
//      - Response: next cycle dbg_cmd_o=0x00, tx_valid_o=0, rx_ready_o=1.

Source files
------------

// File: rtl/dbg_cmd_frontend.sv
// Host byte-stream front end for the debug module: assembles cmd/addr/data frames from RX bytes,
// sequences the cmd/ready handshake with timeouts, and answers with an echo, read data or an error byte.
module dbg_cmd_frontend #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i,
  output logic        err_o
);

  localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_ADDR,
    S_RX_DATA,
    S_ISSUE,
    S_WAIT,
    S_TX
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [39:0]   tx_buf_q, tx_buf_d;
  logic [2:0]    tx_cnt_q, tx_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic          rx_fire;
  logic          tmo_hit;
  logic [31:0]   addr_ins;
  logic [31:0]   data_ins;

  assign rx_ready_o = (state_q == S_IDLE) || (state_q == S_RX_ADDR) || (state_q == S_RX_DATA);
  assign rx_fire    = rx_valid_i & rx_ready_o;
  assign tmo_hit    = (tmo_q == TMO_MAX);
  assign dbg_addr_o = addr_q;
  assign dbg_data_o = data_q;

  // Incoming byte lands in the lane selected by the byte counter (fields arrive LSB first).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign addr_ins[8*gi +: 8] = (byte_cnt_q == 2'(gi)) ? rx_data_i : addr_q[8*gi +: 8];
      assign data_ins[8*gi +: 8] = (byte_cnt_q == 2'(gi)) ? rx_data_i : data_q[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    byte_cnt_d = byte_cnt_q;
    tx_buf_d   = tx_buf_q;
    tx_cnt_d   = tx_cnt_q;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    dbg_cmd_o  = 8'h00;
    err_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid_i) begin
          cmd_d      = rx_data_i;
          addr_d     = 32'h0;
          data_d     = 32'h0;
          byte_cnt_d = 2'd0;
          if (rx_data_i[7]) begin
            state_d = S_RX_ADDR;
          end else if (rx_data_i[6]) begin
            state_d = S_RX_DATA;
          end else if (rx_data_i == 8'h00) begin
            tx_buf_d = {32'h0, rx_data_i};
            tx_cnt_d = 3'd1;
            state_d  = S_TX;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_RX_ADDR: begin
        if (rx_valid_i) begin
          addr_d     = addr_ins;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = cmd_q[6] ? S_RX_DATA : S_ISSUE;
          end
        end else if (tmo_hit) begin
          err_o   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_RX_DATA: begin
        if (rx_valid_i) begin
          data_d     = data_ins;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_ISSUE;
          end
        end else if (tmo_hit) begin
          err_o   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        if (dbg_ready_i) begin
          dbg_cmd_o = cmd_q;
          state_d   = S_WAIT;
        end else if (tmo_hit) begin
          err_o    = 1'b1;
          tx_buf_d = {32'h0, ERR_BYTE};
          tx_cnt_d = 3'd1;
          state_d  = S_TX;
        end
      end

      S_WAIT: begin
        // Completion drops cmd in the same cycle so the debug module never sees it twice.
        if (dbg_ready_i) begin
          if (cmd_q[7:6] == 2'b10) begin
            tx_buf_d = {dbg_data_i, cmd_q};
            tx_cnt_d = 3'd5;
          end else begin
            tx_buf_d = {32'h0, cmd_q};
            tx_cnt_d = 3'd1;
          end
          state_d = S_TX;
        end else if (tmo_hit) begin
          err_o    = 1'b1;
          tx_buf_d = {32'h0, ERR_BYTE};
          tx_cnt_d = 3'd1;
          state_d  = S_TX;
        end else begin
          dbg_cmd_o = cmd_q;
        end
      end

      S_TX: begin
        tx_valid_o = 1'b1;
        tx_data_o  = tx_buf_q[7:0];
        if (tx_ready_i) begin
          tx_buf_d = {8'h00, tx_buf_q[39:8]};
          tx_cnt_d = tx_cnt_q - 3'd1;
          if (tx_cnt_q == 3'd1) begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (rx_fire || (state_d != state_q)) begin
      tmo_d = '0;
    end else if (!tmo_hit) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = tmo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cmd_q      <= 8'h00;
      addr_q     <= 32'h0;
      data_q     <= 32'h0;
      byte_cnt_q <= 2'd0;
      tx_buf_q   <= 40'h0;
      tx_cnt_q   <= 3'd0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      byte_cnt_q <= byte_cnt_d;
      tx_buf_q   <= tx_buf_d;
      tx_cnt_q   <= tx_cnt_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule

// File: tb/tb_dbg_cmd_frontend.sv
// Bench for dbg_cmd_frontend: emulates the host and a debug module, predicts responses from
// the frame rules and compares traffic observed on the DUT ports.
module tb_dbg_cmd_frontend;
  localparam int         TMO  = 16;
  localparam logic [7:0] ERRB = 8'hEE;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          cyc;
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_ev_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic [7:0]  dbg_cmd_o;
  logic [31:0] dbg_addr_o;
  logic [31:0] dbg_data_o;
  logic [31:0] dbg_data_i = 32'h0;
  logic        dbg_ready_i = 1'b1;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  dbg_cmd_frontend #(.TIMEOUT_CYCLES(TMO), .ERR_BYTE(ERRB)) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .dbg_cmd_o  (dbg_cmd_o),
    .dbg_addr_o (dbg_addr_o),
    .dbg_data_o (dbg_data_o),
    .dbg_data_i (dbg_data_i),
    .dbg_ready_i(dbg_ready_i),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  // Port monitor: logs command activity, TX transfers, error pulses and TX hold violations.
  int         cyc = 0;
  cmd_ev_t    cmd_log[$];
  logic [7:0] tx_log[$];
  int         err_cnt = 0;
  int         stable_bad = 0;
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b1;
  logic [7:0] prev_d = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (rst_i) begin
      prev_v = 1'b0;
    end else begin
      if (dbg_cmd_o != 8'h00) cmd_log.push_back('{cyc, dbg_cmd_o, dbg_addr_o, dbg_data_o});
      if (tx_valid_o && tx_ready_i) tx_log.push_back(tx_data_o);
      if (err_o) err_cnt++;
      if (prev_v && !prev_r && (!tx_valid_o || tx_data_o != prev_d)) stable_bad++;
      prev_v = tx_valid_o;
      prev_r = tx_ready_i;
      prev_d = tx_data_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    cmd_log.delete();
    tx_log.delete();
    err_cnt    = 0;
    stable_bad = 0;
  endtask

  // Reference: response bytes from the command, read data and whether it timed out.
  function automatic bq_t exp_tx(input logic [7:0] cmd, input logic [31:0] rd, input bit tmo);
    bq_t q;
    q = {};
    if (tmo) begin
      q.push_back(ERRB);
    end else begin
      q.push_back(cmd);
      if (cmd[7:6] == 2'b10) for (int i = 0; i < 4; i++) q.push_back(rd[8*i +: 8]);
    end
    return q;
  endfunction

  function automatic logic [31:0] field(input bq_t fr, input int off);
    return {fr[off+3], fr[off+2], fr[off+1], fr[off]};
  endfunction

  task automatic send_byte(input string name, input logic [7:0] b);
    bit acc = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    for (int w = 0; w < 64 && !acc; w++) begin
      @(negedge clk);
      #1;
      acc = rx_ready_o;
      tick();
    end
    rx_valid_i = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL %s rx_accept: byte %02h got not-accepted required accepted", name, b);
    end
  endtask

  // Sends one frame, plays the debug module (pre: ready low before issue, lat: busy cycles after
  // issue, stuck: never completes) and the TX sink, then checks everything seen against the model.
  task automatic do_frame(input string name, input bq_t fr, input int gap, input int pre,
                          input int lat, input bit stuck, input logic [31:0] rdata,
                          input int stall_at, input int stall_len, input bit rnd_stall);
    logic [7:0]  cmd;
    logic [31:0] ea, ed;
    bq_t         exp;
    bit          exp_tmo, done, ready;
    int          exp_cmd_n, phase, pre_left, busy_left, stall_left, bad;

    cmd       = fr[0];
    exp_tmo   = (cmd != 8'h00) && (stuck || pre > TMO);
    exp       = exp_tx(cmd, rdata, exp_tmo);
    exp_cmd_n = (cmd == 8'h00 || pre > TMO) ? 0 : (stuck ? TMO + 1 : 1 + lat);
    ea        = cmd[7] ? field(fr, 1) : 32'h0;
    ed        = cmd[6] ? field(fr, cmd[7] ? 5 : 1) : 32'h0;

    clear_logs();
    tx_ready_i  = 1'b1;
    dbg_ready_i = (pre > 0) ? 1'b0 : 1'b1;
    dbg_data_i  = $urandom;
    for (int i = 0; i < fr.size(); i++) begin
      if (i > 0) repeat (gap) tick();
      send_byte(name, fr[i]);
    end

    phase      = (pre > 0) ? 0 : 1;
    pre_left   = pre;
    busy_left  = 0;
    stall_left = stall_len;
    done       = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      ready       = (phase == 1 || phase == 3);
      dbg_ready_i = ready;
      dbg_data_i  = ready ? rdata : $urandom;
      if (stall_left > 0 && tx_valid_o && tx_log.size() == stall_at) begin
        tx_ready_i = 1'b0;
        stall_left--;
      end else begin
        tx_ready_i = rnd_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      @(negedge clk);
      #1;
      if (phase == 0) begin
        pre_left--;
        if (pre_left == 0) phase = 1;
      end else if (phase == 1 && dbg_cmd_o != 8'h00) begin
        if (stuck || lat > 0) begin
          phase     = 2;
          busy_left = lat;
        end else begin
          phase = 3;
        end
      end else if (phase == 2 && !stuck) begin
        busy_left--;
        if (busy_left <= 0) phase = 3;
      end
      done = (tx_log.size() >= exp.size()) && !tx_valid_o;
      tick();
    end
    tx_ready_i  = 1'b1;
    dbg_ready_i = 1'b1;

    $display("frame %s: cmd=%02h len=%0d cmd_cycles=%0d tx_bytes=%0d err_pulses=%0d",
             name, cmd, fr.size(), cmd_log.size(), tx_log.size(), err_cnt);

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s completion: response not finished within cycle budget", name);
    end
    checks++;
    if (tx_log.size() != exp.size()) begin
      errors++;
      $display("FAIL %s tx_len: got %0d required %0d", name, tx_log.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < tx_log.size(); i++) begin
      checks++;
      if (tx_log[i] !== exp[i]) begin
        errors++;
        $display("FAIL %s tx_byte[%0d]: got %02h required %02h", name, i, tx_log[i], exp[i]);
      end
    end
    checks++;
    if (cmd_log.size() != exp_cmd_n) begin
      errors++;
      $display("FAIL %s cmd_cycles: got %0d required %0d", name, cmd_log.size(), exp_cmd_n);
    end
    if (cmd_log.size() > 0) begin
      bad = 0;
      foreach (cmd_log[k]) if (cmd_log[k].cmd !== cmd) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s cmd_value: got %0d cycles with value other than %02h required 0", name, bad, cmd);
      end
      checks++;
      if (cmd_log[$].cyc - cmd_log[0].cyc + 1 != cmd_log.size()) begin
        errors++;
        $display("FAIL %s cmd_contiguous: got span %0d required %0d", name,
                 cmd_log[$].cyc - cmd_log[0].cyc + 1, cmd_log.size());
      end
      checks++;
      if (cmd_log[0].addr !== ea) begin
        errors++;
        $display("FAIL %s dbg_addr: got %08h required %08h", name, cmd_log[0].addr, ea);
      end
      checks++;
      if (cmd_log[0].data !== ed) begin
        errors++;
        $display("FAIL %s dbg_data: got %08h required %08h", name, cmd_log[0].data, ed);
      end
    end
    checks++;
    if (err_cnt != (exp_tmo ? 1 : 0)) begin
      errors++;
      $display("FAIL %s err_pulses: got %0d required %0d", name, err_cnt, exp_tmo ? 1 : 0);
    end
    checks++;
    if (stable_bad != 0) begin
      errors++;
      $display("FAIL %s tx_hold: got %0d unstable stalled cycles required 0", name, stable_bad);
    end
    checks++;
    if (rx_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s rx_ready_after: got %b required 1", name, rx_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    checks += 7;
    if (rx_ready_o !== 1'b1)    begin errors++; $display("FAIL reset rx_ready: got %b required 1", rx_ready_o); end
    if (tx_valid_o !== 1'b0)    begin errors++; $display("FAIL reset tx_valid: got %b required 0", tx_valid_o); end
    if (tx_data_o !== 8'h00)    begin errors++; $display("FAIL reset tx_data: got %02h required 00", tx_data_o); end
    if (dbg_cmd_o !== 8'h00)    begin errors++; $display("FAIL reset dbg_cmd: got %02h required 00", dbg_cmd_o); end
    if (dbg_addr_o !== 32'h0)   begin errors++; $display("FAIL reset dbg_addr: got %08h required 0", dbg_addr_o); end
    if (dbg_data_o !== 32'h0)   begin errors++; $display("FAIL reset dbg_data: got %08h required 0", dbg_data_o); end
    if (err_o !== 1'b0)         begin errors++; $display("FAIL reset err: got %b required 0", err_o); end
    rst_i = 1'b0;
    tick();
    $display("reset: outputs checked");
  endtask

  task automatic test_directed();
    do_frame("mem_write", '{8'hC0, 8'h00, 8'h10, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE},
             0, 0, 3, 1'b0, 32'h0, 0, 0, 1'b0);
    do_frame("mem_read", '{8'h80, 8'h04, 8'h00, 8'h00, 8'h00}, 0, 0, 2, 1'b0, 32'h12345678, 0, 0, 1'b0);
    do_frame("reset_all", '{8'h03}, 0, 0, 0, 1'b0, 32'h0, 0, 0, 1'b0);
    do_frame("ping", '{8'h00}, 0, 0, 0, 1'b0, 32'h0, 0, 0, 1'b0);
    do_frame("issue_wait", '{8'h81, 8'h11, 8'h22, 8'h33, 8'h44}, 0, 4, 1, 1'b0, 32'hCAFEF00D, 0, 0, 1'b0);
  endtask

  task automatic test_timeouts();
    do_frame("wait_timeout", '{8'h04}, 0, 0, 0, 1'b1, 32'h0, 0, 0, 1'b0);
    do_frame("issue_timeout", '{8'h05}, 0, TMO + 4, 0, 1'b0, 32'h0, 0, 0, 1'b0);
    do_frame("complete_at_limit", '{8'h82, 8'h01, 8'h02, 8'h03, 8'h04}, 0, 0, TMO, 1'b0,
             32'hA5A55A5A, 0, 0, 1'b0);
    do_frame("byte_at_limit", '{8'hC1, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80},
             TMO, 0, 1, 1'b0, 32'h0, 0, 0, 1'b0);
  endtask

  task automatic test_partial_frame();
    clear_logs();
    dbg_ready_i = 1'b1;
    send_byte("partial", 8'hC0);
    send_byte("partial", 8'h00);
    repeat (TMO + 9) tick();
    $display("frame partial: cmd=C0 len=2 cmd_cycles=%0d tx_bytes=%0d err_pulses=%0d",
             cmd_log.size(), tx_log.size(), err_cnt);
    checks += 4;
    if (err_cnt != 1)         begin errors++; $display("FAIL partial err_pulses: got %0d required 1", err_cnt); end
    if (tx_log.size() != 0)   begin errors++; $display("FAIL partial tx_len: got %0d required 0", tx_log.size()); end
    if (cmd_log.size() != 0)  begin errors++; $display("FAIL partial cmd_cycles: got %0d required 0", cmd_log.size()); end
    if (rx_ready_o !== 1'b1)  begin errors++; $display("FAIL partial rx_ready: got %b required 1", rx_ready_o); end
    do_frame("after_partial", '{8'h82, 8'h00, 8'h00, 8'h00, 8'h00}, 0, 0, 1, 1'b0, 32'h0BADF00D, 0, 0, 1'b0);
  endtask

  task automatic test_backpressure_reset();
    do_frame("tx_stall", '{8'h82, 8'hEF, 8'hCD, 8'hAB, 8'h89}, 0, 0, 2, 1'b0, 32'h87654321, 2, 5, 1'b0);
    clear_logs();
    dbg_ready_i = 1'b1;
    send_byte("reset_in_wait", 8'h81);
    for (int i = 0; i < 4; i++) send_byte("reset_in_wait", 8'h55);
    tick();
    dbg_ready_i = 1'b0;
    repeat (3) tick();
    checks++;
    if (dbg_cmd_o !== 8'h81) begin
      errors++;
      $display("FAIL reset_in_wait cmd_before: got %02h required 81", dbg_cmd_o);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks += 4;
    if (dbg_cmd_o !== 8'h00)  begin errors++; $display("FAIL reset_in_wait dbg_cmd: got %02h required 00", dbg_cmd_o); end
    if (tx_valid_o !== 1'b0)  begin errors++; $display("FAIL reset_in_wait tx_valid: got %b required 0", tx_valid_o); end
    if (rx_ready_o !== 1'b1)  begin errors++; $display("FAIL reset_in_wait rx_ready: got %b required 1", rx_ready_o); end
    if (dbg_addr_o !== 32'h0) begin errors++; $display("FAIL reset_in_wait dbg_addr: got %08h required 0", dbg_addr_o); end
    $display("frame reset_in_wait: cmd=81 reset applied during WAIT");
    dbg_ready_i = 1'b1;
    do_frame("after_reset", '{8'h02}, 0, 0, 1, 1'b0, 32'h0, 0, 0, 1'b0);
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 30; n++) begin
      bq_t        fr;
      logic [7:0] cmd;
      bit         stuck;
      fr = {};
      case ($urandom_range(0, 3))
        0:       cmd = 8'h80 + 8'($urandom_range(0, 2));
        1:       cmd = 8'hC0 | 8'($urandom_range(0, 63));
        2:       cmd = 8'($urandom_range(1, 63));
        default: cmd = ($urandom_range(0, 1) == 0) ? 8'h00 : (8'h80 | 8'($urandom_range(0, 63)));
      endcase
      fr.push_back(cmd);
      if (cmd[7]) for (int i = 0; i < 4; i++) fr.push_back(8'($urandom));
      if (cmd[6]) for (int i = 0; i < 4; i++) fr.push_back(8'($urandom));
      stuck = ($urandom_range(0, 7) == 0);
      do_frame($sformatf("rand%0d", n), fr, $urandom_range(0, 2), $urandom_range(0, 3),
               $urandom_range(0, 6), stuck, $urandom, 0, 0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeouts();
    test_partial_frame();
    test_backpressure_reset();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
